// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: FSM states, control bundle, default widths.
// Pure declarations; no timing or backpressure of its own.
package pipe_ctrl_pkg;

  localparam int PIPE_COUNTERSIZE = 3;
  localparam int PIPE_CNTW        = 16;

  typedef enum logic [1:0] {
    ST_START    = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALTED   = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic pipe_en;
    logic halted;
  } ctrl_t;

  // Bit order: pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_en, halted
  localparam ctrl_t CTRL_START  = 7'b0011110;
  localparam ctrl_t CTRL_NORMAL = 7'b1100010;
  localparam ctrl_t CTRL_FREEZE = 7'b0000000;
  localparam ctrl_t CTRL_BRANCH = 7'b1111110;
  localparam ctrl_t CTRL_BUBBLE = 7'b0001010;
  localparam ctrl_t CTRL_HALTED = 7'b0000001;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/branch/memory inputs and pipeline enable/flush outputs of the sequencer.
// Slave is the sequencer itself; master drives the hazard and memory-side inputs.
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int COUNTERSIZE = PIPE_COUNTERSIZE,
  parameter int CNTW        = PIPE_CNTW
);
  logic                   stall;
  logic                   branch_taken;
  logic                   exmem_memaccess;
  logic                   dmem_ready;
  logic                   memwb_halt;
  logic [COUNTERSIZE-1:0] stage;
  logic                   pc_write;
  logic                   ifid_write;
  logic                   ifid_flush;
  logic                   idex_flush;
  logic                   exmem_flush;
  logic                   pipe_en;
  logic                   halted;
  logic [CNTW-1:0]        stall_cnt;
  logic [CNTW-1:0]        flush_cnt;

  modport master (
    output stall, branch_taken, exmem_memaccess, dmem_ready, memwb_halt,
    input  stage, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
           pipe_en, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  stall, branch_taken, exmem_memaccess, dmem_ready, memwb_halt,
    output stage, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
           pipe_en, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating event counter with synchronous reset.
// Count visible the cycle after inc; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/pipe_ctrl.sv
// LEGv8 pipeline sequencer: PC/pipeline-register enables and flushes, fill counter, event counters.
// Enables/flushes are zero-latency combinational; a memory wait freezes the whole pipe until dmem_ready.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int COUNTERSIZE = PIPE_COUNTERSIZE,
  parameter int CNTW        = PIPE_CNTW
) (
  input  logic        clk,
  input  logic        reset,
  pipe_ctrl_if.slave  bus
);
  localparam logic [COUNTERSIZE-1:0] STAGE_MAX = '1;

  state_e                 state_q;
  state_e                 state_d;
  logic [COUNTERSIZE-1:0] stage_q;
  logic [COUNTERSIZE-1:0] stage_d;
  ctrl_t                  ctrl;
  logic                   stall_inc;
  logic                   flush_inc;

  always_comb begin
    ctrl      = CTRL_FREEZE;
    state_d   = state_q;
    stall_inc = 1'b0;
    flush_inc = 1'b0;

    unique case (state_q)
      ST_START: begin
        ctrl    = CTRL_START;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.memwb_halt) begin
          ctrl    = CTRL_FREEZE;
          state_d = ST_HALTED;
        end else if (bus.exmem_memaccess && !bus.dmem_ready) begin
          ctrl    = CTRL_FREEZE;
          state_d = ST_MEM_WAIT;
        end else if (bus.branch_taken) begin
          // A concurrent stall belongs to an instruction being squashed.
          ctrl      = CTRL_BRANCH;
          flush_inc = 1'b1;
        end else if (bus.stall && (stage_q >= COUNTERSIZE'(2))) begin
          ctrl      = CTRL_BUBBLE;
          stall_inc = 1'b1;
        end else begin
          ctrl = CTRL_NORMAL;
        end
      end
      ST_MEM_WAIT: begin
        if (bus.dmem_ready) begin
          ctrl    = CTRL_NORMAL;
          state_d = ST_RUN;
        end
      end
      ST_HALTED: begin
        ctrl = CTRL_HALTED;
      end
      default: begin
        state_d = ST_START;
      end
    endcase

    // Reset overrides whatever state is still held so outputs look like START.
    if (reset) begin
      ctrl      = CTRL_START;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
    end

    stage_d = stage_q;
    if ((state_q != ST_START) && ctrl.pipe_en && (stage_q != STAGE_MAX)) begin
      stage_d = stage_q + COUNTERSIZE'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_START;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
    end
  end

  sat_counter #(.WIDTH(CNTW)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (bus.stall_cnt)
  );

  sat_counter #(.WIDTH(CNTW)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (bus.flush_cnt)
  );

  assign bus.stage       = stage_q;
  assign bus.pc_write    = ctrl.pc_write;
  assign bus.ifid_write  = ctrl.ifid_write;
  assign bus.ifid_flush  = ctrl.ifid_flush;
  assign bus.idex_flush  = ctrl.idex_flush;
  assign bus.exmem_flush = ctrl.exmem_flush;
  assign bus.pipe_en     = ctrl.pipe_en;
  assign bus.halted      = ctrl.halted;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl; expected outputs queued per cycle, checked by a negedge monitor.
module tb_pipe_ctrl;
  // Control vector order: pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_en, halted
  localparam logic [6:0] C_START  = 7'b0011110;
  localparam logic [6:0] C_NORMAL = 7'b1100010;
  localparam logic [6:0] C_FREEZE = 7'b0000000;
  localparam logic [6:0] C_BRANCH = 7'b1111110;
  localparam logic [6:0] C_BUBBLE = 7'b0001010;
  localparam logic [6:0] C_HALTED = 7'b0000001;

  typedef struct {
    int         id;
    logic [6:0] ctl;
    int         stg;
    int         sc;
    int         fc;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   cyc_id;
  exp_t exp_q[$];

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int id, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s[cycle %0d]: got %0h want %0h", name, id, got, want);
    end
  endtask

  // Monitor: one expectation per driven cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [6:0] ctl;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      ctl = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_flush,
             bus.exmem_flush, bus.pipe_en, bus.halted};
      check("ctl", e.id, int'(ctl), int'(e.ctl));
      check("stage", e.id, int'(bus.stage), e.stg);
      check("stall_cnt", e.id, int'(bus.stall_cnt), e.sc);
      check("flush_cnt", e.id, int'(bus.flush_cnt), e.fc);
    end
  end

  task automatic cyc(input logic rst, input logic st, input logic bt, input logic ma,
                     input logic rdy, input logic ht, input logic chk,
                     input logic [6:0] ctl, input int stg, input int sc, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    reset               = rst;
    bus.stall           = st;
    bus.branch_taken    = bt;
    bus.exmem_memaccess = ma;
    bus.dmem_ready      = rdy;
    bus.memwb_halt      = ht;
    cyc_id++;
    if (chk) begin
      e.id  = cyc_id;
      e.ctl = ctl;
      e.stg = stg;
      e.sc  = sc;
      e.fc  = fc;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int stg, input int sc, input int fc);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_NORMAL, stg, sc, fc);
  endtask

  initial begin
    int wait_cyc;
    n_checks = 0;
    n_fail   = 0;
    cyc_id   = 0;
    reset               = 1'b1;
    bus.stall           = 1'b0;
    bus.branch_taken    = 1'b0;
    bus.exmem_memaccess = 1'b0;
    bus.dmem_ready      = 1'b1;
    bus.memwb_halt      = 1'b0;

    // Two reset cycles; the second one shows START outputs with cleared state.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_START, 0, 0, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_START, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_START, 0, 0, 0);
    idle(0, 0, 0);
    // Stall at stage 1 is ignored.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_NORMAL, 1, 0, 0);
    idle(2, 0, 0);
    // Stall at stage 3 inserts one bubble.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_BUBBLE, 3, 0, 0);
    idle(4, 1, 0);
    idle(5, 1, 0);
    idle(6, 1, 0);
    idle(7, 1, 0);
    idle(7, 1, 0);
    // Branch wins over a simultaneous stall.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, C_BRANCH, 7, 1, 0);
    idle(7, 1, 1);
    // Four-cycle memory wait with a held branch; branch acts after release.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, C_FREEZE, 7, 1, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, C_FREEZE, 7, 1, 1);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, C_NORMAL, 7, 1, 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, C_BRANCH, 7, 1, 1);
    idle(7, 1, 2);
    // Halt during a memory wait takes priority, then stays halted.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, C_FREEZE, 7, 1, 2);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, C_HALTED, 7, 1, 2);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_START, 7, 1, 2);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_START, 0, 0, 0);
    idle(0, 0, 0);
    idle(1, 0, 0);
    // Long stall run drives stall_cnt into saturation.
    for (int k = 0; k < 70000; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_BUBBLE,
          (k + 2 > 7) ? 7 : k + 2, (k > 65535) ? 65535 : k, 0);
    end
    idle(7, 65535, 0);

    wait_cyc = 0;
    while ((exp_q.size() > 0) && (wait_cyc < 10)) begin
      @(posedge clk);
      wait_cyc++;
    end
    check("drain", cyc_id, exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
